// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MD_LATENCY = 32;
  localparam int MD_CNT_W       = 8;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;
endpackage

// File: rtl/md_stall_timer.sv
// Multiply/divide stall timer: loads on start, counts down while busy,
// and pulses md_done in the last stall cycle of the operation.
module md_stall_timer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = DEF_MD_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic md_done
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = 8'(MD_LATENCY - 1);

  logic [MD_CNT_W-1:0] md_cnt;

  // The start cycle is stall #1, so the count reaching 1 marks the final stall cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= LOAD_VAL;
    end else if (active && (md_cnt != '0)) begin
      md_cnt <= md_cnt - 8'd1;
    end
  end

  assign md_done = reset & active & (md_cnt == 8'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// multiply/divide stalls. Define HAZARD_CTRL_MD_EN to build the md stall path.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = DEF_MD_LATENCY,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dx_is_load,
  input  logic [REG_ADDR_W-1:0] dx_rd,
  input  logic [REG_ADDR_W-1:0] fd_rs,
  input  logic [REG_ADDR_W-1:0] fd_rt,
  input  logic                  fd_uses_rs,
  input  logic                  fd_uses_rt,
  input  logic                  branch_taken,
  input  logic                  md_start,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  dx_en,
  output logic                  fd_flush,
  output logic                  dx_flush,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [31:0]           stall_count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic load_use;
  logic in_md;
  logic md_req;
  logic md_go;

  assign load_use = dx_is_load && (dx_rd != '0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) || (fd_uses_rt && (fd_rt == dx_rd)));

  // Priority: md in progress, then branch, then md start, then load-use.
  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    dx_en    = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    md_go    = 1'b0;
    if (reset) begin
      if (in_md) begin
        pc_en = 1'b0;
        fd_en = 1'b0;
        dx_en = 1'b0;
      end else if (branch_taken) begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end else if (md_req) begin
        pc_en = 1'b0;
        fd_en = 1'b0;
        dx_en = 1'b0;
        md_go = 1'b1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_CTRL_MD_EN
  hz_state_t state;
  logic      md_done_int;

  assign in_md  = (state == MD_BUSY);
  assign md_req = md_start;

  md_stall_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_stall_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (md_go),
    .active (in_md),
    .md_done(md_done_int)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RUN;
    end else if (md_go) begin
      state <= MD_BUSY;
    end else if (md_done_int) begin
      state <= RUN;
    end
  end

  assign md_busy = reset & in_md;
  assign md_done = md_done_int;
`else
  logic [1:0] unused_md;

  assign unused_md = {md_start, md_go};
  assign in_md     = 1'b0;
  assign md_req    = 1'b0;
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pc_en) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; md expectations follow HAZARD_CTRL_MD_EN.
module tb_hazard_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dx_is_load = 1'b0;
  logic [4:0]  dx_rd = '0;
  logic [4:0]  fd_rs = '0;
  logic [4:0]  fd_rt = '0;
  logic        fd_uses_rs = 1'b0;
  logic        fd_uses_rt = 1'b0;
  logic        branch_taken = 1'b0;
  logic        md_start = 1'b0;
  logic        pc_en, fd_en, dx_en, fd_flush, dx_flush, md_busy, md_done;
  logic [31:0] stall_count;
  logic [6:0]  outs;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MD_LATENCY(4), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .branch_taken(branch_taken), .md_start(md_start), .pc_en(pc_en), .fd_en(fd_en),
    .dx_en(dx_en), .fd_flush(fd_flush), .dx_flush(dx_flush), .md_busy(md_busy),
    .md_done(md_done), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // {pc_en, fd_en, dx_en, fd_flush, dx_flush, md_busy, md_done}
  assign outs = {pc_en, fd_en, dx_en, fd_flush, dx_flush, md_busy, md_done};

  task automatic drive(input logic rst, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic br, input logic ms);
    @(negedge clock);
    reset = rst; dx_is_load = ld; dx_rd = rd; fd_rs = rs; fd_rt = rt;
    fd_uses_rs = urs; fd_uses_rt = urt; branch_taken = br; md_start = ms;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_idle();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL idle_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b0010100) begin n_fail++; $display("FAIL lu_rs_outs: got %b want %b", outs, 7'b0010100); end
    tick();
    n_checks++;
    if (stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_rs_count: got %0d want 1", stall_count); end
    drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL lu_after_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_after_count: got %0d want 1", stall_count); end
    drive(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b0010100) begin n_fail++; $display("FAIL lu_rt_outs: got %b want %b", outs, 7'b0010100); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL lu_rt_count: got %0d want 2", stall_count); end
    drive(1'b1, 1'b1, 5'd6, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL lu_nomatch_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL lu_nomatch_count: got %0d want 2", stall_count); end
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL lu_unused_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL lu_unused_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL rd0_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL rd0_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (outs !== 7'b1111100) begin n_fail++; $display("FAIL br_lu_outs: got %b want %b", outs, 7'b1111100); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL br_lu_count: got %0d want 2", stall_count); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (outs !== 7'b1111100) begin n_fail++; $display("FAIL br_md_outs: got %b want %b", outs, 7'b1111100); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL br_md_count: got %0d want 2", stall_count); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL br_md_next_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL br_md_next_count: got %0d want 2", stall_count); end
  endtask

`ifdef HAZARD_CTRL_MD_EN
  task automatic test_md();
    logic [6:0] exp_outs [0:4];
    exp_outs[0] = 7'b0000000;
    exp_outs[1] = 7'b0000010;
    exp_outs[2] = 7'b0000010;
    exp_outs[3] = 7'b0000011;
    exp_outs[4] = 7'b1110000;
    for (int c = 0; c < 5; c++) begin
      // md_start held and a branch raised mid-operation must both be ignored.
      drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, (c == 2), (c < 4));
      if (c == 4) begin
        dx_is_load = 1'b0;
        #1;
      end
      n_checks++;
      if (outs !== exp_outs[c]) begin n_fail++; $display("FAIL md_cycle%0d_outs: got %b want %b", c, outs, exp_outs[c]); end
      tick();
    end
    n_checks++;
    if (stall_count !== 32'd6) begin n_fail++; $display("FAIL md_count: got %0d want 6", stall_count); end
  endtask

  task automatic test_md_abort();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b0000010) begin n_fail++; $display("FAIL abort_busy_outs: got %b want %b", outs, 7'b0000010); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL abort_rst_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL abort_rst_count: got %0d want 0", stall_count); end
    for (int c = 3; c < 5; c++) begin
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (outs !== 7'b1110000) begin n_fail++; $display("FAIL abort_cycle%0d_outs: got %b want %b", c, outs, 7'b1110000); end
      tick();
    end
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL abort_count: got %0d want 0", stall_count); end
  endtask
`else
  task automatic test_md_disabled();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL mdoff_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL mdoff_count: got %0d want 2", stall_count); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL mdoff_hold_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL mdoff_hold_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_count_reset();
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (outs !== 7'b1110000) begin n_fail++; $display("FAIL cntrst_outs: got %b want %b", outs, 7'b1110000); end
    tick();
    n_checks++;
    if (stall_count !== 32'd0) begin n_fail++; $display("FAIL cntrst_count: got %0d want 0", stall_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_rd_zero();
    test_branch();
`ifdef HAZARD_CTRL_MD_EN
    test_md();
    test_md_abort();
`else
    test_md_disabled();
    test_count_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
